// File: rtl/arb_mux_pkg.sv
// Shared definitions for the arbitrated multiplexer: policy codes and the
// channel-index width helper.
package arb_mux_pkg;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    // Width of a channel index; at least one bit even for tiny channel counts.
    function automatic int unsigned ch_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Combinational grant selection: fixed priority or round-robin from ptr.
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    input  logic              mode,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   idx
);

    // Scan channels starting at ptr (round-robin) or 0 (fixed); first requester wins.
    always_comb begin
        int unsigned start;
        logic [CH_W-1:0] c;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        c     = '0;
        start = mode ? 32'(ptr) : 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            c = CH_W'((start + i) % NUM_CH);
            if (!found && req[c]) begin
                grant[c] = 1'b1;
                idx      = c;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N-to-1 arbitrated multiplexer with a single registered output slot.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned MODE   = ARB_RR,
    localparam int unsigned CH_W  = ch_w(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]         out_ch,
    input  logic                    out_ready
);

    logic [CH_W-1:0]   ptr;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   gidx;
    logic [WIDTH-1:0]  sel_data;
    logic              slot_free;
    logic              take;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req   (in_valid),
        .ptr   (ptr),
        .mode  (MODE == ARB_RR),
        .grant (grant),
        .idx   (gidx)
    );

    // Offer the grant only while the output slot can take a word and reset is released.
    always_comb begin
        slot_free = !out_valid || out_ready;
        in_ready  = (slot_free && resetn) ? grant : '0;
        take      = |in_ready;
    end

    // One-hot AND-OR select of the granted channel's data.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (grant[i]) sel_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    // Output slot and round-robin pointer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_ch    <= gidx;
            ptr       <= (gidx == CH_W'(NUM_CH - 1)) ? '0 : gidx + 1'b1;
        end else if (slot_free) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: three instances (4ch round-robin, 4ch fixed, 3ch
// round-robin) driven in lockstep and checked against a queue-based model.
module tb_arb_mux;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 4 channels, round-robin
    logic [3:0]   iv_a = '0, ir_a;
    logic [127:0] id_a = '0;
    logic         ov_a, ordy_a = 1'b0;
    logic [31:0]  od_a;
    logic [1:0]   oc_a;
    // Instance B: 4 channels, fixed priority
    logic [3:0]   iv_b = '0, ir_b;
    logic [127:0] id_b = '0;
    logic         ov_b, ordy_b = 1'b0;
    logic [31:0]  od_b;
    logic [1:0]   oc_b;
    // Instance C: 3 channels, round-robin
    logic [2:0]   iv_c = '0, ir_c;
    logic [95:0]  id_c = '0;
    logic         ov_c, ordy_c = 1'b0;
    logic [31:0]  od_c;
    logic [1:0]   oc_c;

    arb_mux #(.WIDTH(32), .NUM_CH(4), .MODE(1)) dut_a (
        .clk(clk), .resetn(resetn), .in_valid(iv_a), .in_data(id_a), .in_ready(ir_a),
        .out_valid(ov_a), .out_data(od_a), .out_ch(oc_a), .out_ready(ordy_a));
    arb_mux #(.WIDTH(32), .NUM_CH(4), .MODE(0)) dut_b (
        .clk(clk), .resetn(resetn), .in_valid(iv_b), .in_data(id_b), .in_ready(ir_b),
        .out_valid(ov_b), .out_data(od_b), .out_ch(oc_b), .out_ready(ordy_b));
    arb_mux #(.WIDTH(32), .NUM_CH(3), .MODE(1)) dut_c (
        .clk(clk), .resetn(resetn), .in_valid(iv_c), .in_data(id_c), .in_ready(ir_c),
        .out_valid(ov_c), .out_data(od_c), .out_ch(oc_c), .out_ready(ordy_c));

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Reference model state per instance
    int          nch [3] = '{4, 4, 3};
    int          rr  [3] = '{1, 0, 1};
    int          m_v [3];
    int          m_c [3];
    int          m_p [3];
    logic [31:0] m_d [3];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_v[k] = 0; m_c[k] = 0; m_p[k] = 0; m_d[k] = '0;
        end
    endtask

    // Channel chosen by the policy, or -1 when nobody requests.
    function automatic int exp_grant(input int id, input logic [3:0] req);
        int order[$];
        if (rr[id] == 0) begin
            for (int c = 0; c < nch[id]; c++) order.push_back(c);
        end else begin
            for (int c = m_p[id]; c < nch[id]; c++) order.push_back(c);
            for (int c = 0; c < m_p[id]; c++) order.push_back(c);
        end
        foreach (order[k]) if (req[order[k]]) return order[k];
        return -1;
    endfunction

    // Compare one instance against the model, then advance the model over the coming edge.
    task automatic check_one(input int id, input logic [3:0] iv, input logic [127:0] dat,
                             input logic ordy, input logic [3:0] ir, input logic ov,
                             input logic [31:0] od, input logic [3:0] oc);
        int g;
        logic free;
        logic [3:0] eir;
        free = (m_v[id] == 0) || ordy;
        g = exp_grant(id, iv);
        eir = '0;
        if (resetn && free && g >= 0) eir[g] = 1'b1;
        chk($sformatf("d%0d_out_valid", id), 64'(ov), 64'(m_v[id]));
        chk($sformatf("d%0d_out_data", id), 64'(od), 64'(m_d[id]));
        chk($sformatf("d%0d_out_ch", id), 64'(oc), 64'(m_c[id]));
        chk($sformatf("d%0d_in_ready", id), 64'(ir), 64'(eir));
        if (resetn) begin
            if (free && g >= 0) begin
                m_v[id] = 1;
                m_d[id] = dat[g*32 +: 32];
                m_c[id] = g;
                if (rr[id] != 0) m_p[id] = (g + 1) % nch[id];
            end else if (free) begin
                m_v[id] = 0;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_one(0, iv_a, id_a, ordy_a, ir_a, ov_a, od_a, {2'b0, oc_a});
        check_one(1, iv_b, id_b, ordy_b, ir_b, ov_b, od_b, {2'b0, oc_b});
        check_one(2, {1'b0, iv_c}, {32'b0, id_c}, ordy_c, {1'b0, ir_c}, ov_c, od_c, {2'b0, oc_c});
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        id_a = {$urandom, $urandom, $urandom, $urandom};
        id_b = {$urandom, $urandom, $urandom, $urandom};
        id_c = {$urandom, $urandom, $urandom};
    endtask

    task automatic set_ready(input logic r);
        ordy_a = r; ordy_b = r; ordy_c = r;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held_d;
        logic [1:0]  held_c;
        model_reset();

        // Reset state, requests present but blocked by reset
        iv_a = 4'hF; iv_b = 4'hF; iv_c = 3'b111; rand_data(); set_ready(1'b1);
        #1;
        cycle();
        cycle();
        resetn = 1'b1;

        // Continuous requests: RR 0..3 on A, fixed ch1 on B, 3ch wrap on C
        iv_a = 4'b1111; iv_b = 4'b1010; iv_c = 3'b111; set_ready(1'b1);
        for (int k = 0; k < 8; k++) begin
            rand_data();
            cycle();
            chk("rr4_seq_ch", 64'(oc_a), 64'(k % 4));
            chk("rr4_seq_valid", 64'(ov_a), 64'd1);
            chk("fixed_ch1", 64'(oc_b), 64'd1);
            chk("rr3_wrap_ch", 64'(oc_c), 64'(k % 3));
        end

        // Stall: out_ready low while requests vary
        held_d = od_a; held_c = oc_a;
        set_ready(1'b0);
        for (int k = 0; k < 5; k++) begin
            iv_a = 4'($urandom); iv_b = 4'($urandom); iv_c = 3'($urandom); rand_data();
            cycle();
            chk("stall_data", 64'(od_a), 64'(held_d));
            chk("stall_ch", 64'(oc_a), 64'(held_c));
            chk("stall_valid", 64'(ov_a), 64'd1);
        end

        // Single-cycle request on channel 2
        set_ready(1'b1);
        iv_a = 4'b0100; iv_b = 4'b0100; iv_c = 3'b100; rand_data();
        id_a[64 +: 32] = 32'hDEADBEEF;
        cycle();
        chk("single_valid", 64'(ov_a), 64'd1);
        chk("single_data", 64'(od_a), 64'hDEADBEEF);
        chk("single_ch", 64'(oc_a), 64'd2);
        iv_a = '0; iv_b = '0; iv_c = '0;
        cycle();
        chk("single_drain", 64'(ov_a), 64'd0);
        chk("single_hold_data", 64'(od_a), 64'hDEADBEEF);

        // Randomized traffic with random back-pressure
        for (int k = 0; k < 150; k++) begin
            iv_a = 4'($urandom); iv_b = 4'($urandom); iv_c = 3'($urandom); rand_data();
            ordy_a = ($urandom_range(3) != 0);
            ordy_b = ($urandom_range(3) != 0);
            ordy_c = ($urandom_range(3) != 0);
            cycle();
        end

        // Asynchronous reset mid-burst
        iv_a = 4'hF; iv_b = 4'hF; iv_c = 3'b111; set_ready(1'b1); rand_data();
        cycle();
        cycle();
        chk("pre_reset_valid", 64'(ov_a), 64'd1);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        chk("async_rst_valid", 64'(ov_a), 64'd0);
        chk("async_rst_data", 64'(od_a), 64'd0);
        chk("async_rst_ch", 64'(oc_a), 64'd0);
        chk("async_rst_ready", 64'(ir_a), 64'd0);
        chk("async_rst_valid_c", 64'(ov_c), 64'd0);
        @(posedge clk);
        #1;
        cycle();
        resetn = 1'b1;
        iv_a = 4'b1111; iv_b = 4'b1111; iv_c = 3'b111; rand_data();
        cycle();
        chk("post_reset_ch", 64'(oc_a), 64'd0);
        chk("post_reset_valid", 64'(ov_a), 64'd1);
        cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
